// File: rtl/pulse_gen.sv
// Programmable pulse-burst generator: `count` pulses of `width` high cycles
// separated by max(`gap`,1) low cycles, with abort and a completion strobe.
module pulse_gen #(
    parameter int WW = 5,
    parameter int GW = 8,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [WW-1:0] i_width,
    input  logic [GW-1:0] i_gap,
    input  logic [CW-1:0] i_count,
    output logic          o_pulse_out,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_sent
);

    localparam int XW = (WW > GW) ? WW : GW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [XW-1:0] r_cnt, w_cnt_next;
    logic [WW-1:0] r_width, w_width_next;
    logic [GW-1:0] r_gap, w_gap_next;
    logic [CW-1:0] r_count, w_count_next;
    logic [CW-1:0] r_sent, w_sent_next;
    logic          r_pulse, r_busy, r_done;
    logic          w_pulse_next, w_busy_next, w_done_next;

    logic          w_accept;
    logic          w_degen;
    logic          w_high_end;
    logic          w_last;
    logic [CW-1:0] w_sent_inc;
    logic [XW-1:0] w_width_load;
    logic [XW-1:0] w_gap_load;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_degen      = (i_width == '0) || (i_count == '0);
    assign w_high_end   = (r_state == S_HIGH) && !i_abort && (r_cnt == XW'(1));
    assign w_sent_inc   = r_sent + CW'(1);
    assign w_last       = (w_sent_inc == r_count);
    assign w_width_load = XW'(r_width);
    // A zero gap still produces one low cycle so every pulse has both edges.
    assign w_gap_load   = (r_gap == '0) ? XW'(1) : XW'(r_gap);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_width_next = r_width;
        w_gap_next   = r_gap;
        w_count_next = r_count;
        w_sent_next  = r_sent;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_width_next = i_width;
                    w_gap_next   = i_gap;
                    w_count_next = i_count;
                    w_sent_next  = '0;
                    if (!w_degen) begin
                        w_state_next = S_HIGH;
                        w_cnt_next   = XW'(i_width);
                    end
                end
            end
            S_HIGH: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == XW'(1)) begin
                    w_sent_next = w_sent_inc;
                    if (w_last) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_LOW;
                        w_cnt_next   = w_gap_load;
                    end
                end else begin
                    w_cnt_next = r_cnt - XW'(1);
                end
            end
            S_LOW: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == XW'(1)) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = w_width_load;
                end else begin
                    w_cnt_next = r_cnt - XW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so pulse_out comes straight off a flop.
    always_comb begin
        w_pulse_next = (w_state_next == S_HIGH);
        w_busy_next  = (w_state_next != S_IDLE);
        w_done_next  = (w_accept && w_degen) || (w_high_end && w_last);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_width <= '0;
            r_gap   <= '0;
            r_count <= '0;
            r_sent  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_width <= w_width_next;
            r_gap   <= w_gap_next;
            r_count <= w_count_next;
            r_sent  <= w_sent_next;
            r_pulse <= w_pulse_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign o_pulse_out = r_pulse;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_sent      = r_sent;

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse-burst generator; the transmit-side counterpart to the pulse-width discriminator. On a start command it drives a train of `count` single-bit pulses, each exactly `width` clock cycles high and separated by `gap` low cycles. It is the stimulus source for discriminator calibration and loopback self-test, where its `pulse_out` feeds the discriminator's pulse input directly.

## Interface
- `WW`, 5: width of the `width` field; matches the discriminator's 5-bit width counter.
- `GW`, 8: width of the `gap` field.
- `CW`, 8: width of the `count` and `sent` fields.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command; sampled only when `busy`=0.
- `abort`  in  1  terminates any burst in progress.
- `width`  in  WW  pulse high time in cycles; latched on an accepted start.
- `gap`  in  GW  low time between pulses in cycles; latched on an accepted start.
- `count`  in  CW  number of pulses in the burst; latched on an accepted start.
- `pulse_out`  out  1  generated pulse train; registered.
- `busy`  out  1  burst in progress; registered.
- `done`  out  1  one-cycle strobe when a burst ends normally.
- `sent`  out  CW  pulses fully completed in the current or last burst.

## Operation
- Reset values: `pulse_out`=0, `busy`=0, `done`=0, `sent`=0, FSM=IDLE, all latched config = 0.
- States:
  - IDLE: wait for start.
  - HIGH: `pulse_out`=1, down-counting the width.
  - LOW: `pulse_out`=0, down-counting the gap.
- Start accepted when `start`=1 and `busy`=0, including the `done` cycle. An accepted start:
  - latches `width`, `gap`, `count`;
  - clears `sent`;
  - sets `busy`.
- `start` while `busy`=1 is ignored. Config inputs are don't-care outside the accept cycle.
- Degenerate config: `width`=0 or `count`=0.
  - No pulse is generated; `pulse_out` stays 0.
  - Next cycle: `done`=1, `busy`=0, `sent`=0.
- IDLE -> HIGH on an accepted start with non-degenerate config.
- HIGH:
  - Remains for exactly `width` cycles.
  - On leaving, `sent` increments.
  - If `sent`+1 == `count` -> IDLE, with `done`=1 and `busy`=0 in the first low cycle. No trailing gap is applied.
  - Otherwise -> LOW.
- LOW:
  - Remains for max(`gap`,1) cycles, then -> HIGH.
  - `gap`=0 is forced to 1 so the receiver always sees a falling and a rising edge.
- `abort` (when `busy`=1) takes priority over all transitions:
  - next cycle: FSM=IDLE, `pulse_out`=0, `busy`=0;
  - `done` is not asserted;
  - `sent` holds the count of completed pulses; a truncated pulse is not counted.
- `abort` with `busy`=0 has no effect. `abort` and `start` in the same cycle with `busy`=0: start wins.
- Arithmetic:
  - Counters are unsigned with no wrap.
  - `width` max 31 and `gap` max 255 are honoured exactly.
  - `count`=255 yields 255 pulses.

## Timing
- Start accepted at edge N: `pulse_out` rises at edge N+1 and `busy`=1 from N+1.
- Pulse k (k=0..count-1) is high on cycles N+1+k·(W+G') through N+k·(W+G')+W, where W=`width` and G'=max(`gap`,1).
- `done` is high for exactly one cycle, the cycle after the last high cycle. `busy` falls in the same cycle.
- Burst length from accept to `done`: count·W + (count−1)·G' cycles, plus 1.
- Asynchronous `rst_n` assertion mid-burst:
  - all outputs go to reset values immediately, without waiting for a clock;
  - after release, the first start is accepted on the first rising edge with `rst_n`=1.
- `pulse_out` is glitch-free because it is driven directly from a flop.

## Test plan
- Nominal burst:
  - Stimulus: width=6, gap=3, count=4, start at cycle 10.
  - Required: highs on cycles 11-16, 20-25, 29-34, 38-43; `done` at cycle 44; `sent`=4; `busy` high on cycles 11-43.
- Edge cases:
  - width=1, gap=0, count=3 -> alternating 1,0,1,0,1, then `done`.
  - width=0, count=5 -> no pulse; `done` the next cycle; `sent`=0.
  - count=0 -> no pulse; `done` the next cycle; `sent`=0.
- Abort during the 2nd pulse:
  - Stimulus: width=8, gap=2, count=5.
  - Required: `pulse_out` low the next cycle, `busy`=0, no `done`, `sent`=1.
- Start ignored while busy; back-to-back start in the `done` cycle is accepted, and the new burst's first pulse starts the following cycle with no idle gap.
- Async reset asserted mid-HIGH:
  - `pulse_out`, `busy`, `sent` go to 0 without a clock edge.
  - A new burst with width=5, count=1 after release gives exactly 5 high cycles.
- Loopback into the discriminator with width 4, 5 and 6:
  - width=4 produces no detection;
  - width=5 and width=6 each produce one detect per pulse.
